// File: rtl/tetris_io_pkg.sv
// Shared definitions for the keyboard MMIO path: dmem addresses, the PS/2
// frame state encoding and the queued key-entry layout.
package tetris_io_pkg;

    localparam logic [11:0] KEY_DATA_ADDR = 12'hFFF;
    localparam logic [11:0] KEY_STAT_ADDR = 12'hFFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    typedef struct packed {
        logic       brk;
        logic [7:0] code;
    } key_entry_t;

    // True when the 8 data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Pointer FIFO of key entries. Pointers carry one extra wrap bit so that
// full and empty are distinguishable. A pop on the same cycle as a push to a
// full FIFO frees the slot, so the push is accepted.
module ps2_key_fifo
    import tetris_io_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  key_entry_t               wr_entry,
    input  logic                     pop,
    output key_entry_t               rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    key_entry_t     mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           do_push;
    logic           do_pop;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    // Accept/reject decisions and next pointer values.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        drop     = push & full & ~do_pop;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

endmodule

// File: rtl/ps2_key_mmio.sv
// PS/2 keyboard receiver with a scancode FIFO read through two dmem
// addresses (0xFFF pops data, 0xFFE returns {overflow, count} and clears
// overflow). Optional feature macro: PS2_BREAK_MERGE_EN folds a 0xF0 prefix
// into the brk bit of the following key entry.
module ps2_key_mmio
    import tetris_io_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [11:0] address_dmem,
    input  logic        rden,
    output logic [31:0] q_key,
    output logic        key_pending,
    output logic        overflow
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    // Synchroniser and edge detector
    logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic fall;

    // Timeout
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;

    // Frame FSM
    ps2_state_e    state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic          frame_valid_q;
    logic [7:0]    frame_byte_q;

    // Push stage
    logic          push_q, push_d;
    key_entry_t    push_entry_q, push_entry_d;
`ifdef PS2_BREAK_MERGE_EN
    logic          brk_pending_q, brk_pending_d;
`endif

    // FIFO and MMIO
    key_entry_t    rd_entry;
    logic          fifo_full, fifo_empty, fifo_drop, pop;
    logic [CW-1:0] fifo_count;
    logic [31:0]   q_key_q, q_key_d;
    logic          overflow_q, overflow_d;

    // Two-flop synchronisers plus one history flop for the clock edge.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // Synchroniser registers idle high like the PS/2 lines.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
        end
    end

    // Saturating count of cycles since the last PS/2 falling edge.
    always_comb begin
        if (fall) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT)) && (state_q != ST_IDLE);

    // Timeout counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Frame FSM: start, 8 data bits LSB first, parity, stop; flags a good byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            par_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_byte_q  <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            if (tmo_hit) begin
                state_q <= ST_IDLE;
            end else if (fall) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
                            frame_valid_q <= 1'b1;
                            frame_byte_q  <= shift_q;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Turn a validated byte into a FIFO push (optionally merging 0xF0).
    always_comb begin
        push_d       = 1'b0;
        push_entry_d = push_entry_q;
`ifdef PS2_BREAK_MERGE_EN
        brk_pending_d = brk_pending_q;
        if (tmo_hit) begin
            brk_pending_d = 1'b0;
        end
        if (frame_valid_q) begin
            if (frame_byte_q == 8'hF0) begin
                brk_pending_d = 1'b1;
            end else begin
                push_d            = 1'b1;
                push_entry_d.brk  = brk_pending_q;
                push_entry_d.code = frame_byte_q;
                brk_pending_d     = 1'b0;
            end
        end
`else
        if (frame_valid_q) begin
            push_d            = 1'b1;
            push_entry_d.brk  = 1'b0;
            push_entry_d.code = frame_byte_q;
        end
`endif
    end

    // Push stage registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            push_q        <= 1'b0;
            push_entry_q  <= '0;
`ifdef PS2_BREAK_MERGE_EN
            brk_pending_q <= 1'b0;
`endif
        end else begin
            push_q        <= push_d;
            push_entry_q  <= push_entry_d;
`ifdef PS2_BREAK_MERGE_EN
            brk_pending_q <= brk_pending_d;
`endif
        end
    end

    ps2_key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_q),
        .wr_entry (push_entry_q),
        .pop      (pop),
        .rd_entry (rd_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop),
        .count    (fifo_count)
    );

    // Load decode: register read data, pop on data reads, sticky overflow
    // where a new drop outranks a same-cycle status-read clear.
    always_comb begin
        pop        = 1'b0;
        q_key_d    = q_key_q;
        overflow_d = overflow_q;
        if (rden) begin
            case (address_dmem)
                KEY_DATA_ADDR: begin
                    pop     = 1'b1;
                    q_key_d = fifo_empty ? '0 : {23'b0, rd_entry};
                end
                KEY_STAT_ADDR: begin
                    q_key_d    = {24'b0, overflow_q, 7'(fifo_count)};
                    overflow_d = 1'b0;
                end
                default: q_key_d = '0;
            endcase
        end
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    // Read data and overflow registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_key_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            q_key_q    <= q_key_d;
            overflow_q <= overflow_d;
        end
    end

    assign q_key       = q_key_q;
    assign overflow    = overflow_q;
    assign key_pending = ~fifo_empty;

endmodule

// File: doc/ps2_key_mmio.md
# ps2_key_mmio

Memory-mapped keyboard input stage that sits directly upstream of the processor's data-memory path. It receives PS/2 frames from the keyboard, validates them, and queues scancodes in a small FIFO. The processor reads them with ordinary loads at two reserved dmem addresses. Game code polls the status word and pops key events without touching the PS/2 protocol.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, range 2–64.
- TIMEOUT, 5000: system-clock cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- clock, in, 1: master clock shared with the processor.
- reset, in, 1: reset, asynchronous, active-low.
- ps2_clk, in, 1: raw PS/2 clock, asynchronous to clock.
- ps2_data, in, 1: raw PS/2 data, asynchronous to clock.
- address_dmem, in, 12: processor dmem address.
- rden, in, 1: processor load strobe, high for one cycle per load.
- q_key, out, 32: read data returned to the processor load mux.
- key_pending, out, 1: high while the FIFO is non-empty.
- overflow, out, 1: sticky flag; a frame was dropped because the FIFO was full.

## Operation
- **Input synchroniser.** ps2_clk and ps2_data each pass through a 2-flop synchroniser. A falling edge is detected on the synchronised ps2_clk, and data is sampled on that edge.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE → DATA on an edge with data=0 (start bit). An edge with data=1 stays in IDLE.
  - DATA shifts 8 bits, LSB first. After the 8th bit it goes to PARITY.
  - PARITY latches the bit, then goes to STOP.
  - STOP: the frame is valid only if data=1 and the 9 bits (data + parity) have odd parity.
    - Valid frame: push the byte.
    - Invalid frame: discard it silently.
    - Either way, return to IDLE.
- **Timeout.** The timeout counter clears on every falling edge and increments otherwise. When it reaches TIMEOUT in any state other than IDLE, the FSM returns to IDLE and the partial frame is discarded.
- **FIFO.** Each entry is 9 bits: {brk, code[7:0]}. Read and write pointers are log2(DEPTH)+1 bits with wrap-around. The count ranges 0..DEPTH.
- **Reading the FIFO.**
  - Address 0xFFF (KEY_DATA): the load returns {23'b0, brk, code} and pops one entry. When the FIFO is empty it returns 0 and does not pop.
  - Address 0xFFE (KEY_STAT): the load returns {24'b0, overflow, count[6:0]}, then clears overflow.
  - rden with any other address: q_key = 0 and no side effects.
- **Push when full.** The byte is dropped and overflow is set. The exception is a simultaneous pop on the same cycle: the pop frees a slot, the push succeeds, and overflow is not set.
- **Overflow vs status read.** If overflow is set and KEY_STAT is read on the same cycle, the set wins.
- **Push and pop on an empty FIFO.** The pop sees empty and returns 0; the push lands.

## Timing
- Reset values: q_key=0, key_pending=0, overflow=0, FIFO empty, FSM in IDLE, counters 0. Reset takes effect immediately and asynchronously, including mid-frame; the partial frame is lost.
- Load latency is one cycle. q_key is registered: it is valid on the cycle after rden and held until the next rden.
  - The pop takes effect on the same edge that registers q_key.
  - key_pending reflects the post-pop count on the following cycle.
- Push latency: the entry becomes visible (key_pending=1) 3 cycles after the synchronised falling edge that samples the stop bit.
- Throughput is one push per cycle maximum, and the PS/2 rate is far lower. Back-to-back loads are supported: one pop per cycle.

## Configuration
- Macro: `PS2_BREAK_MERGE_EN`.
  - **Defined:** a valid 0xF0 byte is not pushed; it sets an internal brk_pending flag. The next valid byte is pushed with brk=1, which clears the flag. The flag also clears on timeout and on reset.
  - **Undefined:** every valid byte is pushed raw, including 0xF0, and brk is always 0.

## Structure
- Shared package `tetris_io_pkg` holds:
  - KEY_DATA_ADDR (12'hFFF) and KEY_STAT_ADDR (12'hFFE);
  - the PS/2 frame state enum;
  - the 9-bit key-entry typedef.
- One sub-module, `ps2_key_fifo`: the parameterised pointer FIFO with push, pop, full, empty and count. The top block holds the synchroniser, the frame FSM, the break merge and the MMIO decode.

## Test plan
1. Send a valid frame for 0x1D (parity 1, stop 1) → key_pending rises; a load at 0xFFF returns 32'h0000001D; key_pending falls the next cycle.
2. Send a frame for 0x1D with a bad parity bit → no push, key_pending stays 0, and a KEY_STAT read returns 0.
3. Send DEPTH+1 valid frames with no reads → KEY_STAT returns {overflow=1, count=8}; a second KEY_STAT read returns overflow=0.
4. With the FIFO full, inject a push and a 0xFFF load on the same cycle → the oldest code is returned, count stays 8, overflow stays 0.
5. Send 4 bits of a frame, idle for TIMEOUT cycles, then send a valid 0x75 frame → only 0x75 is queued.
6. With PS2_BREAK_MERGE_EN defined, send 0xF0 then 0x6B → a single entry reads 32'h0000016B. With the macro undefined, the same input gives two entries, 0xF0 then 0x6B.
